// File: rtl/rr_fifo_push_arbiter_pkg.sv
// Shared constants and width helpers for the round-robin FIFO push arbiter.
package rr_fifo_push_arbiter_pkg;

  localparam int unsigned DEFAULT_NUM_REQ    = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH      = 8;

  // A single producer still needs a one-bit index field.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return (max_cnt > 0) ? $clog2(max_cnt + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_fifo_push_arbiter_fifo_v3.sv
// Non-fall-through FIFO: a pushed entry becomes visible at the head one cycle later.
module rr_fifo_push_arbiter_fifo_v3 #(
  parameter int unsigned DEPTH = 8,
  parameter type dtype = logic [31:0],
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic testmode_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned UW = ADDR_W + 1;

  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [UW-1:0]     usage_q;
  logic              do_push;
  logic              do_pop;
  logic              unused_testmode;
  dtype              mem [DEPTH];

  // No clock gating here, so the test-mode input has nothing to bypass.
  assign unused_testmode = testmode_i;

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  assign full_o  = (usage_q == UW'(DEPTH));
  assign empty_o = (usage_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign data_o  = mem[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      usage_q <= usage_q + UW'(1);
      else if (do_pop && !do_push) usage_q <= usage_q - UW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rr_fifo_push_arbiter.sv
// Round-robin arbiter pushing NUM_REQ producers into one shared FIFO,
// with a per-producer occupancy cap so no producer can hog the buffer.
module rr_fifo_push_arbiter
  import rr_fifo_push_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEFAULT_NUM_REQ,
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned MAX_PER_REQ = DEPTH,
  parameter type dtype = logic [DATA_WIDTH-1:0],
  localparam int unsigned IDX_WIDTH = idx_width(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 testmode_i,
  input  logic [NUM_REQ-1:0]   valid_i,
  output logic [NUM_REQ-1:0]   ready_o,
  input  dtype                 data_i [NUM_REQ],
  output logic                 valid_o,
  input  logic                 ready_i,
  output dtype                 data_o,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned CNT_W = cnt_width(MAX_PER_REQ);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PER_REQ);

  typedef struct packed {
    logic [IDX_WIDTH-1:0] idx;
    dtype                 data;
  } entry_t;

  typedef struct packed {
    logic                 found;
    logic [IDX_WIDTH-1:0] idx;
  } pick_t;

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   inc;
  logic [NUM_REQ-1:0]   dec;
  logic [CNT_W-1:0]     cnt_q [NUM_REQ];
  logic [IDX_WIDTH-1:0] rr_q;
  pick_t                pick;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  entry_t               push_entry;
  entry_t               head;

  // First requester at or after start, wrapping modulo NUM_REQ.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [IDX_WIDTH-1:0] start);
    pick_t       res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(start) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!res.found && req[j]) begin
        res.found = 1'b1;
        res.idx   = IDX_WIDTH'(j);
      end
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign elig[gi]    = valid_i[gi] & (cnt_q[gi] < MAX_CNT) & ~fifo_full & ~flush_i & rst_ni;
    assign ready_o[gi] = pick.found & (pick.idx == IDX_WIDTH'(gi));
    assign inc[gi]     = ready_o[gi];
    assign dec[gi]     = pop & (head.idx == IDX_WIDTH'(gi));
  end

  assign pick = rr_pick(elig, rr_q);
  assign push = pick.found;

  always_comb begin
    push_entry      = '0;
    push_entry.idx  = pick.idx;
    push_entry.data = data_i[pick.idx];
  end

  assign valid_o = ~fifo_empty & ~flush_i;
  assign pop     = valid_o & ready_i;
  assign full_o  = fifo_full;
  assign empty_o = fifo_empty;

  // Head is forced to zero while empty so stale memory never leaks out.
  always_comb begin
    data_o = '0;
    idx_o  = '0;
    if (!fifo_empty) begin
      data_o = head.data;
      idx_o  = head.idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (flush_i) begin
      rr_q <= '0;
    end else if (pick.found) begin
      rr_q <= (pick.idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : pick.idx + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inc[i] && !dec[i])      cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        else if (dec[i] && !inc[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
      end
    end
  end

  rr_fifo_push_arbiter_fifo_v3 #(
    .DEPTH (DEPTH),
    .dtype (entry_t)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .testmode_i (testmode_i),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .data_i     (push_entry),
    .push_i     (push),
    .data_o     (head),
    .pop_i      (pop)
  );

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ready_o));
  a_no_grant_full: assert property (@(posedge clk_i) disable iff (!rst_ni) full_o |-> (ready_o == '0));
  a_max_range: assert property (@(posedge clk_i) (MAX_PER_REQ >= 1) && (MAX_PER_REQ <= DEPTH));
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chk
    a_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(inc[gi] && !dec[gi] && (cnt_q[gi] == MAX_CNT)));
    a_no_unf: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec[gi] && !inc[gi] && (cnt_q[gi] == '0)));
    a_valid_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_i[gi] && !ready_o[gi] && !flush_i) |=> valid_i[gi]);
  end
`endif

endmodule

// File: tb/tb_rr_fifo_push_arbiter.sv
// Directed bench: driver pushes expected {idx,data} entries on each expected
// grant; an independent monitor checks the head whenever valid_o is shown.
module tb_rr_fifo_push_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        testmode_i;
  logic [3:0]  valid_i;
  logic [3:0]  ready_o;
  logic [31:0] data_i [4];
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [1:0]  idx_o;
  logic        full_o;
  logic        empty_o;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [15:0] seq    = 16'h0;
  logic [33:0] exp_q [$];

  always #5 clk = ~clk;

  rr_fifo_push_arbiter #(
    .NUM_REQ     (4),
    .DATA_WIDTH  (32),
    .DEPTH       (8),
    .MAX_PER_REQ (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush_i),
    .testmode_i (testmode_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .idx_o      (idx_o),
    .full_o     (full_o),
    .empty_o    (empty_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares the head against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head_unexpected actual idx=%0d data=%0h required none", idx_o, data_o);
      end else begin
        check("head_idx", 64'(idx_o), 64'(exp_q[0][33:32]));
        check("head_data", 64'(data_o), 64'(exp_q[0][31:0]));
        if (ready_i) begin
          void'(exp_q.pop_front());
          pops++;
          $display("pop idx=%0d data=%0h", idx_o, data_o);
        end
      end
    end
  end

  task automatic step(input logic [3:0] v, input logic rdy, input logic fl,
                      input logic [3:0] exp_rdy, input string name);
    valid_i = v;
    ready_i = rdy;
    flush_i = fl;
    for (int p = 0; p < 4; p++) data_i[p] = {8'hD0 + 8'(p), 8'h00, seq};
    seq++;
    @(negedge clk);
    check(name, 64'(ready_o), 64'(exp_rdy));
    $display("%s valid=%b ready_i=%b flush=%b ready_o=%b", name, v, rdy, fl, ready_o);
    if (fl) begin
      check({name, "_valid_o"}, 64'(valid_o), 64'(0));
      exp_q.delete();
    end
    for (int p = 0; p < 4; p++)
      if (exp_rdy[p]) exp_q.push_back({2'(p), data_i[p]});
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_o"}, 64'(ready_o), 64'(0));
    check({tag, "_valid_o"}, 64'(valid_o), 64'(0));
    check({tag, "_data_o"},  64'(data_o),  64'(0));
    check({tag, "_idx_o"},   64'(idx_o),   64'(0));
    check({tag, "_full_o"},  64'(full_o),  64'(0));
    check({tag, "_empty_o"}, 64'(empty_o), 64'(1));
  endtask

  logic [3:0] t1_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                             4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] t3_exp [5] = '{4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] t5_exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    rst_n      = 1'b0;
    flush_i    = 1'b0;
    testmode_i = 1'b0;
    valid_i    = '0;
    ready_i    = 1'b0;
    for (int p = 0; p < 4; p++) data_i[p] = '0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 1: all producers, consumer always ready.
    for (int k = 0; k < 8; k++) step(4'hF, 1'b1, 1'b0, t1_exp[k], "t1_grant");
    step(4'hF, 1'b1, 1'b1, 4'b0000, "t1_flush");
    check("t1_empty", 64'(empty_o), 64'(1));
    step(4'h0, 1'b1, 1'b0, 4'b0000, "t1_idle");

    // Test 2: limit of 2 on producer 1, producer 2 taken the same cycle.
    step(4'b0010, 1'b0, 1'b0, 4'b0010, "t2_p1_a");
    step(4'b0010, 1'b0, 1'b0, 4'b0010, "t2_p1_b");
    step(4'b0010, 1'b0, 1'b0, 4'b0000, "t2_p1_limit");
    step(4'b0110, 1'b0, 1'b0, 4'b0100, "t2_p2_same");

    // Test 3: fill to 8, block while full, one pop frees exactly one grant.
    for (int k = 0; k < 5; k++) step(4'hF, 1'b0, 1'b0, t3_exp[k], "t3_fill");
    check("t3_full", 64'(full_o), 64'(1));
    step(4'hF, 1'b0, 1'b0, 4'b0000, "t3_full_block");
    step(4'hF, 1'b1, 1'b0, 4'b0000, "t3_pop_full");
    step(4'hF, 1'b0, 1'b0, 4'b0010, "t3_one_grant");
    step(4'hF, 1'b0, 1'b0, 4'b0000, "t3_full_again");
    check("t3_full_again_flag", 64'(full_o), 64'(1));
    step(4'hF, 1'b0, 1'b1, 4'b0000, "t3_flush");
    check("t3_empty", 64'(empty_o), 64'(1));
    check("t3_not_full", 64'(full_o), 64'(0));

    // Test 4: push and pop of producer 0 in the same cycle keep its count.
    step(4'b0001, 1'b0, 1'b0, 4'b0001, "t4_push");
    step(4'b0001, 1'b1, 1'b0, 4'b0001, "t4_push_pop");
    step(4'b0001, 1'b0, 1'b0, 4'b0001, "t4_cnt_kept");
    step(4'b0001, 1'b0, 1'b0, 4'b0000, "t4_limit");
    step(4'b0001, 1'b1, 1'b0, 4'b0000, "t4_pop_a");
    step(4'b0001, 1'b1, 1'b0, 4'b0001, "t4_pop_b");
    step(4'b0000, 1'b1, 1'b0, 4'b0000, "t4_drain");
    check("t4_empty", 64'(empty_o), 64'(1));

    // Test 5: five buffered entries, flush clears fifo, pointer and counters.
    for (int k = 0; k < 5; k++) step(4'hF, 1'b0, 1'b0, t5_exp[k], "t5_fill");
    check("t5_not_empty", 64'(empty_o), 64'(0));
    step(4'hF, 1'b0, 1'b1, 4'b0000, "t5_flush");
    check("t5_empty", 64'(empty_o), 64'(1));
    step(4'hF, 1'b0, 1'b0, 4'b0001, "t5_rr_zero");
    step(4'hF, 1'b0, 1'b0, 4'b0010, "t5_cnt_zero");
    step(4'hF, 1'b0, 1'b0, 4'b0100, "t5_third");

    // Test 6: asynchronous reset with three entries buffered.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'hF, 1'b1, 1'b0, 4'b0001, "t6_first");
    step(4'hF, 1'b1, 1'b0, 4'b0010, "t6_second");
    step(4'hF, 1'b1, 1'b0, 4'b0100, "t6_third");
    step(4'hF, 1'b1, 1'b0, 4'b1000, "t6_fourth");
    step(4'hF, 1'b1, 1'b1, 4'b0000, "t6_flush");
    step(4'h0, 1'b1, 1'b0, 4'b0000, "t6_idle");
    check("t6_empty", 64'(empty_o), 64'(1));
    check("total_pops", 64'(pops), 64'(15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
